// File: rtl/squared_length_if.sv
// Handshake bundle between the vector producer, squared_length and the
// square-root stage.
//   in_valid/in_ready : vector handshake, x/y/z signed Q(IN_W-4).4 components
//   out_valid/out_ready : result handshake, A unsigned with 4 fraction bits
//   is_zero           : A == 0, meaningful while out_valid is high
//   start             : one-cycle pulse to the square-root stage on handoff
// slave is the squared_length side, master the producer/consumer side.
interface squared_length_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 12
);
  logic                   in_valid;
  logic                   in_ready;
  logic signed [IN_W-1:0] x;
  logic signed [IN_W-1:0] y;
  logic signed [IN_W-1:0] z;
  logic                   out_valid;
  logic                   out_ready;
  logic [OUT_W-1:0]       A;
  logic                   is_zero;
  logic                   start;

  modport slave (
    input  in_valid, x, y, z, out_ready,
    output in_ready, out_valid, A, is_zero, start
  );

  modport master (
    output in_valid, x, y, z, out_ready,
    input  in_ready, out_valid, A, is_zero, start
  );
endinterface

// File: rtl/squared_length.sv
// squared_length: computes x*x + y*y + z*z of a signed fixed-point vector
// with one shared multiplier (three cycles), then reduces it to OUT_W bits
// with 4 fraction bits, saturating to all ones, and offers it on a
// valid/ready handshake. start pulses on the cycle the result is taken.
// Ports:
//   clk  : clock
//   rst_ : synchronous reset, active-high
//   bus  : squared_length_if.slave (in_valid/in_ready/x/y/z,
//          out_valid/out_ready/A/is_zero/start)
// Build option: define SQUARED_LENGTH_ROUND_EN for round-half-up on the
// dropped fraction bits; otherwise they are truncated.
module squared_length #(
  parameter int IN_W    = 8,
  parameter int FRAC_IN = 4,
  parameter int OUT_W   = 12
) (
  input  logic            clk,
  input  logic            rst_,
  squared_length_if.slave bus
);

  localparam int ACC_W = 2*IN_W + 2;
  localparam int DROP  = 2*FRAC_IN - 4;
`ifdef SQUARED_LENGTH_ROUND_EN
  // One extra bit so the rounding increment cannot wrap.
  localparam int SUM_W = ACC_W + 1;
`else
  localparam int SUM_W = ACC_W;
`endif

  typedef enum logic [2:0] {IDLE, MUL_X, MUL_Y, MUL_Z, FORMAT, HOLD} state_t;

  state_t state, next_state;

  logic signed [IN_W-1:0]   x_r, y_r, z_r;
  logic signed [IN_W-1:0]   op;
  logic signed [2*IN_W-1:0] op_ext;
  logic signed [2*IN_W-1:0] prod;
  logic [ACC_W-1:0]         prod_ext;
  logic [ACC_W-1:0]         acc;
  logic [SUM_W-1:0]         sum;
  logic [SUM_W-1:0]         shifted;
  logic [OUT_W-1:0]         a_sat;
  logic [OUT_W-1:0]         a_r;
  logic                     is_zero_r;
  logic                     out_valid_r;
  logic                     accept;
  logic                     start;

  assign accept = bus.in_valid && (state == IDLE);
  assign start  = (state == HOLD) && out_valid_r && bus.out_ready;

  // Shared multiplier: operand chosen by the current MUL_* state.
  always_comb begin
    op = z_r;
    case (state)
      MUL_X:   op = x_r;
      MUL_Y:   op = y_r;
      default: op = z_r;
    endcase
  end

  assign op_ext = (2*IN_W)'(op);
  assign prod   = op_ext * op_ext;
  // A square is never negative, so zero extension is exact.
  assign prod_ext = ACC_W'($unsigned(prod));

  // Reduce to 4 fraction bits, then clamp anything above OUT_W bits.
  always_comb begin
`ifdef SQUARED_LENGTH_ROUND_EN
    sum = {1'b0, acc} + (SUM_W'(1) << (DROP - 1));
`else
    sum = acc;
`endif
    shifted = sum >> DROP;
    if (|shifted[SUM_W-1:OUT_W]) a_sat = '1;
    else                         a_sat = shifted[OUT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst_) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.in_valid) next_state = MUL_X;
      MUL_X:   next_state = MUL_Y;
      MUL_Y:   next_state = MUL_Z;
      MUL_Z:   next_state = FORMAT;
      FORMAT:  next_state = HOLD;
      HOLD:    if (start) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      x_r         <= '0;
      y_r         <= '0;
      z_r         <= '0;
      acc         <= '0;
      a_r         <= '0;
      is_zero_r   <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      if (accept) begin
        x_r <= bus.x;
        y_r <= bus.y;
        z_r <= bus.z;
      end
      case (state)
        MUL_X:        acc <= prod_ext;
        MUL_Y, MUL_Z: acc <= acc + prod_ext;
        FORMAT: begin
          a_r         <= a_sat;
          is_zero_r   <= (a_sat == '0);
          out_valid_r <= 1'b1;
        end
        HOLD:    if (start) out_valid_r <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_r;
  assign bus.A         = a_r;
  assign bus.is_zero   = is_zero_r;
  assign bus.start     = start;

endmodule

// File: tb/tb_squared_length.sv
module tb_squared_length;

  logic clk;
  logic rst_;
  int   checks;
  int   failures;
  int   cyc;

  squared_length_if #(.IN_W(8), .OUT_W(12)) bus ();

  squared_length #(
    .IN_W   (8),
    .FRAC_IN(4),
    .OUT_W  (12)
  ) dut (
    .clk (clk),
    .rst_(rst_),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: exact sum of squares in units of 1/256, rescaled to 1/16.
  function automatic logic [11:0] model(input logic signed [7:0] a,
                                        input logic signed [7:0] b,
                                        input logic signed [7:0] c);
    int ia, ib, ic, s, r;
    ia = a; ib = b; ic = c;
    s = ia*ia + ib*ib + ic*ic;
`ifdef SQUARED_LENGTH_ROUND_EN
    r = (s + 8) / 16;
`else
    r = s / 16;
`endif
    if (r > 4095) r = 4095;
    return 12'(r);
  endfunction

  // Caller is positioned just after a negedge with the DUT idle.
  task automatic do_vector(input logic [7:0] vx, input logic [7:0] vy,
                           input logic [7:0] vz, input logic [11:0] exp_a,
                           input int hold, input string name);
    int k;
    logic hold_ok;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s idle: in_ready=%b expected 1", name, bus.in_ready);
    end
    bus.in_valid = 1'b1; bus.x = vx; bus.y = vy; bus.z = vz;
    @(negedge clk);
    // Inputs change after acceptance and must not matter.
    bus.in_valid = 1'b0;
    bus.x = 8'($urandom); bus.y = 8'($urandom); bus.z = 8'($urandom);
    k = 0;
    while (bus.out_valid !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k != 4) begin
      failures++;
      $display("FAIL %s latency: cycles=%0d expected 4", name, k);
    end
    checks++;
    if (bus.A !== exp_a) begin
      failures++;
      $display("FAIL %s A: got %h expected %h", name, bus.A, exp_a);
    end
    checks++;
    if (bus.is_zero !== (exp_a == 12'h000)) begin
      failures++;
      $display("FAIL %s is_zero: got %b expected %b", name, bus.is_zero, exp_a == 12'h000);
    end
    hold_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      if (bus.out_valid !== 1'b1 || bus.A !== exp_a || bus.start !== 1'b0 ||
          bus.in_ready !== 1'b0) hold_ok = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (!hold_ok || bus.start !== 1'b0) begin
      failures++;
      $display("FAIL %s hold: stable=%b start=%b expected stable=1 start=0", name, hold_ok, bus.start);
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.start !== 1'b1) begin
      failures++;
      $display("FAIL %s start: got %b expected 1", name, bus.start);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.start !== 1'b0) begin
      failures++;
      $display("FAIL %s release: out_valid=%b in_ready=%b start=%b expected 0 1 0",
               name, bus.out_valid, bus.in_ready, bus.start);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_ = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL reset in_ready: got %b expected 1", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL reset out_valid: got %b expected 0", bus.out_valid);
    end
    checks++;
    if (bus.A !== 12'h000) begin
      failures++; $display("FAIL reset A: got %h expected 000", bus.A);
    end
    checks++;
    if (bus.is_zero !== 1'b0 || bus.start !== 1'b0) begin
      failures++;
      $display("FAIL reset is_zero/start: got %b/%b expected 0/0", bus.is_zero, bus.start);
    end
  endtask

  task automatic test_directed();
    logic [11:0] round_exp;
`ifdef SQUARED_LENGTH_ROUND_EN
    round_exp = 12'h001;
`else
    round_exp = 12'h000;
`endif
    do_vector(8'h10, 8'h20, 8'h20, 12'h090, 0, "basic");
    do_vector(8'hD0, 8'h40, 8'h00, 12'h190, 1, "negative");
    do_vector(8'h80, 8'h80, 8'h80, 12'hC00, 2, "max");
    do_vector(8'h00, 8'h00, 8'h00, 12'h000, 0, "zero");
    do_vector(8'h03, 8'h00, 8'h00, round_exp, 0, "round");
  endtask

  task automatic test_random();
    logic [7:0] vx, vy, vz;
    for (int i = 0; i < 20; i++) begin
      vx = 8'($urandom); vy = 8'($urandom); vz = 8'($urandom);
      do_vector(vx, vy, vz, model(vx, vy, vz), $urandom_range(0, 3), "random");
    end
  endtask

  task automatic test_backpressure();
    logic [11:0] exp_a;
    logic ok;
    int k;
    exp_a = model(8'h25, 8'hE7, 8'h11);
    bus.in_valid = 1'b1; bus.x = 8'h25; bus.y = 8'hE7; bus.z = 8'h11;
    @(negedge clk);
    bus.x = 8'h7F; bus.y = 8'h7F; bus.z = 8'h7F;   // in_valid stays high
    k = 0;
    while (bus.out_valid !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    ok = (k == 4);
    for (int i = 0; i < 10; i++) begin
      if (bus.out_valid !== 1'b1 || bus.A !== exp_a || bus.in_ready !== 1'b0 ||
          bus.start !== 1'b0) ok = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL backpressure hold: A=%h out_valid=%b in_ready=%b start=%b expected A=%h 1 0 0",
               bus.A, bus.out_valid, bus.in_ready, bus.start, exp_a);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.start !== 1'b1 || bus.A !== exp_a) begin
      failures++;
      $display("FAIL backpressure start: start=%b A=%h expected 1 %h", bus.start, bus.A, exp_a);
    end
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.start !== 1'b0) begin
      failures++;
      $display("FAIL backpressure release: in_ready=%b start=%b expected 1 0", bus.in_ready, bus.start);
    end
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || bus.start !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL backpressure ignored: spurious out_valid/start after release, expected none");
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic ok;
    bus.in_valid = 1'b1; bus.x = 8'h70; bus.y = 8'h70; bus.z = 8'h70;
    @(negedge clk);                 // MUL_X
    bus.in_valid = 1'b0;
    @(negedge clk);                 // MUL_Y
    rst_ = 1'b1;
    @(negedge clk);
    rst_ = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.A !== 12'h000) begin
      failures++;
      $display("FAIL reset_mid state: in_ready=%b out_valid=%b A=%h expected 1 0 000",
               bus.in_ready, bus.out_valid, bus.A);
    end
    bus.out_ready = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || bus.start !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL reset_mid aborted: out_valid/start seen for aborted vector, expected none");
    end
    bus.out_ready = 1'b0;
    do_vector(8'hF8, 8'h18, 8'hC4, model(8'hF8, 8'h18, 8'hC4), 1, "after_reset");
  endtask

  task automatic test_back_to_back();
    logic [7:0]  vx, vy, vz;
    logic [11:0] exp_a;
    int prev_cyc, acc_cyc, n;
    bus.out_ready = 1'b1;
    prev_cyc = 0;
    for (int i = 0; i < 6; i++) begin
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 10) begin
        @(negedge clk);
        n++;
      end
      vx = 8'($urandom); vy = 8'($urandom); vz = 8'($urandom);
      exp_a = model(vx, vy, vz);
      bus.in_valid = 1'b1; bus.x = vx; bus.y = vy; bus.z = vz;
      @(negedge clk);
      acc_cyc = cyc;
      bus.x = 8'($urandom); bus.y = 8'($urandom); bus.z = 8'($urandom);
      if (i > 0) begin
        checks++;
        if (acc_cyc - prev_cyc != 6) begin
          failures++;
          $display("FAIL b2b spacing: got %0d cycles expected 6", acc_cyc - prev_cyc);
        end
      end
      prev_cyc = acc_cyc;
      n = 0;
      while (bus.start !== 1'b1 && n < 10) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (bus.start !== 1'b1 || bus.A !== exp_a) begin
        failures++;
        $display("FAIL b2b result: start=%b A=%h expected 1 %h", bus.start, bus.A, exp_a);
      end
      if (i == 5) bus.in_valid = 1'b0;
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0;
    rst_ = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.x = '0; bus.y = '0; bus.z = '0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/squared_length.md
Name: squared_length

Overview:
- Upstream feeder for the square-root stage.
- Takes a 3-component signed fixed-point vector and computes x²+y²+z² sequentially with one shared multiplier.
- Formats the sum into the 12-bit, 4-fraction-bit operand the square-root stage accepts.
- Presents the result over a valid/ready handshake, with a one-cycle start pulse that drives the square-root stage's start input.

Parameters:
- IN_W, 8, component width (two's complement, FRAC_IN fraction bits)
- FRAC_IN, 4, fraction bits of each input component
- OUT_W, 12, output width (unsigned, 4 fraction bits)

Ports:
- clk  in  1  clock
- rst_  in  1  synchronous reset, active-high
- in_valid  in  1  vector present
- in_ready  out  1  block can accept a vector
- x, y, z  in  IN_W each  signed components, Q(IN_W-FRAC_IN).FRAC_IN
- out_valid  out  1  A valid, held until accepted
- out_ready  in  1  consumer accepts A
- A  out  OUT_W  squared length, 4 fraction bits, unsigned
- is_zero  out  1  A==0, qualified by out_valid
- start  out  1  out_valid & out_ready; one-cycle pulse to the square-root stage

Behaviour:
- Reset, sampled on posedge clk with rst_=1: state IDLE; A=0, is_zero=0, out_valid=0, accumulator=0. in_ready=1 in the first cycle after reset.
- rst_ asserted mid-operation aborts the operation. The captured vector is discarded and no out_valid or start is produced for it.
- in_ready = (state==IDLE), combinational from state.
- FSM states: IDLE, MUL_X, MUL_Y, MUL_Z, FORMAT, HOLD.
- IDLE: in_valid&in_ready at edge E0 captures x, y, z into registers; go to MUL_X.
- MUL_X: acc = x*x (signed×signed, 2*IN_W-bit product, non-negative); go to MUL_Y.
- MUL_Y: acc += y*y; go to MUL_Z.
- MUL_Z: acc += z*z; go to FORMAT. Accumulator width is 2*IN_W+2, so no overflow is possible.
- FORMAT: reduce acc from 2*FRAC_IN fraction bits to 4 fraction bits by dropping (2*FRAC_IN-4) LSBs, per the optional feature. Then saturate:
  - if the result exceeds 2^OUT_W-1, A = all ones;
  - register A and is_zero, set out_valid=1, go to HOLD.
- Latency: out_valid is first high after edge E0+4.
- HOLD: A, is_zero and out_valid stay stable while out_ready=0.
  - When out_valid&out_ready, start is high for that cycle; next edge: out_valid=0, go to IDLE.
  - in_valid is ignored outside IDLE.
  - Throughput: one vector per 6 cycles minimum.
- start is never high outside HOLD.
- Inputs x, y, z are sampled only at acceptance; later changes have no effect.
- With defaults the maximum is 3*(-8.0)² = 192.0, giving A=0xC00, so saturation is unreachable. Saturation logic is still mandatory for wider IN_W.

Optional Feature:
- Macro: SQUARED_LENGTH_ROUND_EN.
- Defined: round-half-up; add 2^(2*FRAC_IN-5) before dropping LSBs. Rounding that carries past the maximum saturates to all ones.
- Undefined: plain truncation of the dropped LSBs.

Test Plan:
- Basic sum: x=0x10 (1.0), y=0x20 (2.0), z=0x20 -> out_valid 4 cycles after accept; A=0x090 (9.0); is_zero=0; start pulses once when out_ready=1.
- Negative components: x=0xD0 (-3.0), y=0x40 (4.0), z=0x00 -> A=0x190 (25.0).
- Extremes:
  - x=y=z=0x80 (-8.0) -> A=0xC00.
  - x=y=z=0x00 -> A=0x000, is_zero=1.
- Rounding: x=0x03, y=z=0 (raw sum 9/256) -> A=0x001 with SQUARED_LENGTH_ROUND_EN defined; A=0x000 without.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> A and out_valid stable, in_ready=0, start=0, new in_valid ignored. Then out_ready=1 -> single start pulse; in_ready=1 on the next cycle.
- Reset mid-operation: assert rst_ for one cycle in MUL_Y -> next cycle IDLE, out_valid=0, A=0; no start for the aborted vector. The next vector then completes normally.
